// File: rtl/saturn_jump_pkg.sv
// Shared types and jump-length codes for the Saturn jump pre-decoder and PC/RSTK block.
// Optional feature macro: SATURN_COND_JUMP_EN (adds GOC/GONC decode and the SKIP state).
package saturn_jump_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBlk0,
        StBlk8,
        StOffset,
        StSkip
    } jump_state_e;

    localparam logic [2:0] JL_NONE = 3'd0;
    localparam logic [2:0] JL_REL2 = 3'd1;
    localparam logic [2:0] JL_REL3 = 3'd2;
    localparam logic [2:0] JL_REL4 = 3'd3;
    localparam logic [2:0] JL_ABS5 = 3'd4;

    // A jump of length code L consumes L+1 offset nibbles.
    localparam logic [2:0] SKIP_LAST = 3'd1;

endpackage

// File: rtl/saturn_jump_opcode_lut.sv
// Combinational opcode map: (state, nibble, carry) -> (next state, length, push, other).
// Optional feature macro: SATURN_COND_JUMP_EN (decodes 4/5 as GOC/GONC).
module saturn_jump_opcode_lut
    import saturn_jump_pkg::*;
(
    input  jump_state_e state_i,
    input  logic [3:0]  nibble_i,
    input  logic        carry_i,
    output jump_state_e next_state_o,
    output logic [2:0]  length_o,
    output logic        push_o,
    output logic        other_o
);

`ifndef SATURN_COND_JUMP_EN
    logic unused_carry;
    assign unused_carry = carry_i;
`endif

    always_comb begin
        next_state_o = StIdle;
        length_o     = JL_NONE;
        push_o       = 1'b0;
        other_o      = 1'b0;
        unique case (state_i)
            StIdle: begin
                case (nibble_i)
                    4'h0: next_state_o = StBlk0;
                    4'h8: next_state_o = StBlk8;
                    4'h6: begin
                        next_state_o = StOffset;
                        length_o     = JL_REL3;
                    end
                    4'h7: begin
                        next_state_o = StOffset;
                        length_o     = JL_REL3;
                        push_o       = 1'b1;
                    end
`ifdef SATURN_COND_JUMP_EN
                    4'h4, 4'h5: begin
                        // GOC takes the jump on carry set, GONC on carry clear.
                        if ((nibble_i == 4'h4) == carry_i) begin
                            next_state_o = StOffset;
                            length_o     = JL_REL2;
                        end else begin
                            next_state_o = StSkip;
                        end
                    end
`endif
                    default: other_o = 1'b1;
                endcase
            end
            StBlk8: begin
                case (nibble_i)
                    4'hC: begin
                        next_state_o = StOffset;
                        length_o     = JL_REL4;
                    end
                    4'hD: begin
                        next_state_o = StOffset;
                        length_o     = JL_ABS5;
                    end
                    4'hE: begin
                        next_state_o = StOffset;
                        length_o     = JL_REL4;
                        push_o       = 1'b1;
                    end
                    4'hF: begin
                        next_state_o = StOffset;
                        length_o     = JL_ABS5;
                        push_o       = 1'b1;
                    end
                    default: other_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/saturn_jump_decoder.sv
// Nibble-serial pre-decoder for Saturn RTN/GOTO/GOSUB/GOLONG-family control transfers.
// Optional feature macro: SATURN_COND_JUMP_EN (GOC/GONC with SKIP of untaken offsets).
module saturn_jump_decoder
    import saturn_jump_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clk_en,
    input  logic [3:0] i_phases,
    input  logic       i_bus_busy,
    input  logic       i_exec_unit_busy,
    input  logic [3:0] i_nibble,
    input  logic       i_instr_start,
    input  logic       i_carry,
    output logic       o_jump_instr,
    output logic [2:0] o_jump_length,
    output logic       o_push_pc,
    output logic       o_block_0x,
    output logic       o_other_instr,
    output logic       o_busy
);

    jump_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic        jump_q, jump_d;
    logic        push_q, push_d;
    logic        blk0_q, blk0_d;
    logic        other_q, other_d;

    jump_state_e lut_next;
    logic [2:0]  lut_len;
    logic        lut_push;
    logic        lut_other;
    logic        slot;

    logic unused_phases;
    assign unused_phases = ^{i_phases[3], i_phases[1:0]};

    assign slot = i_clk_en & i_phases[2] & ~i_bus_busy & ~i_exec_unit_busy;

    saturn_jump_opcode_lut u_lut (
        .state_i     (state_q),
        .nibble_i    (i_nibble),
        .carry_i     (i_carry),
        .next_state_o(lut_next),
        .length_o    (lut_len),
        .push_o      (lut_push),
        .other_o     (lut_other)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        jump_d  = jump_q;
        push_d  = push_q;
        blk0_d  = blk0_q;
        other_d = other_q;
        if (slot) begin
            other_d = 1'b0;
            unique case (state_q)
                StIdle, StBlk8: begin
                    // Instruction-start only matters in IDLE; BLK8 decodes its second nibble.
                    if (i_instr_start || (state_q == StBlk8)) begin
                        state_d = lut_next;
                        cnt_d   = 3'd0;
                        len_d   = lut_len;
                        push_d  = lut_push;
                        jump_d  = (lut_next == StOffset);
                        blk0_d  = (lut_next == StBlk0);
                        other_d = lut_other;
                    end
                end
                StBlk0: begin
                    blk0_d  = 1'b0;
                    state_d = StIdle;
                end
                StOffset: begin
                    if (cnt_q == len_q) begin
                        jump_d  = 1'b0;
                        len_d   = JL_NONE;
                        push_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StSkip: begin
                    if (cnt_q == SKIP_LAST) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            len_q   <= JL_NONE;
            jump_q  <= 1'b0;
            push_q  <= 1'b0;
            blk0_q  <= 1'b0;
            other_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            jump_q  <= jump_d;
            push_q  <= push_d;
            blk0_q  <= blk0_d;
            other_q <= other_d;
        end
    end

    assign o_jump_instr  = jump_q;
    assign o_jump_length = len_q;
    assign o_push_pc     = push_q;
    assign o_block_0x    = blk0_q;
    assign o_other_instr = other_q;
    assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_saturn_jump_decoder.sv
// Randomized bench for saturn_jump_decoder against a nibble-counting reference model.
// Honours SATURN_COND_JUMP_EN the same way the design does.
module tb_saturn_jump_decoder;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_clk_en = 1'b0;
    logic [3:0] i_phases = 4'b0000;
    logic       i_bus_busy = 1'b0;
    logic       i_exec_unit_busy = 1'b0;
    logic [3:0] i_nibble = 4'h0;
    logic       i_instr_start = 1'b0;
    logic       i_carry = 1'b0;
    logic       o_jump_instr;
    logic [2:0] o_jump_length;
    logic       o_push_pc;
    logic       o_block_0x;
    logic       o_other_instr;
    logic       o_busy;

    saturn_jump_decoder dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_clk_en        (i_clk_en),
        .i_phases        (i_phases),
        .i_bus_busy      (i_bus_busy),
        .i_exec_unit_busy(i_exec_unit_busy),
        .i_nibble        (i_nibble),
        .i_instr_start   (i_instr_start),
        .i_carry         (i_carry),
        .o_jump_instr    (o_jump_instr),
        .o_jump_length   (o_jump_length),
        .o_push_pc       (o_push_pc),
        .o_block_0x      (o_block_0x),
        .o_other_instr   (o_other_instr),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks what kind of instruction is in flight and how many nibbles remain.
    localparam int M_IDLE = 0;
    localparam int M_AFTER0 = 1;
    localparam int M_AFTER8 = 2;
    localparam int M_OFFSET = 3;
    localparam int M_SKIP = 4;

    int   m_mode = M_IDLE;
    int   m_rem  = 0;
    bit   e_jump, e_push, e_blk, e_other;
    int   e_len;

    task automatic model_jump(input int len, input bit push);
        e_jump = 1;
        e_len  = len;
        e_push = push;
        m_rem  = len + 1;
        m_mode = M_OFFSET;
    endtask

    task automatic model_step(input bit rst, input bit slot, input bit start,
                              input logic [3:0] nib, input bit carry);
        if (rst) begin
            m_mode = M_IDLE; m_rem = 0;
            e_jump = 0; e_len = 0; e_push = 0; e_blk = 0; e_other = 0;
            return;
        end
        if (!slot) return;
        e_other = 0;
        case (m_mode)
            M_IDLE: if (start) begin
                if (nib == 4'h0) begin
                    m_mode = M_AFTER0; e_blk = 1;
                end else if (nib == 4'h8) begin
                    m_mode = M_AFTER8;
                end else if (nib == 4'h6 || nib == 4'h7) begin
                    model_jump(2, nib == 4'h7);
`ifdef SATURN_COND_JUMP_EN
                end else if (nib == 4'h4 || nib == 4'h5) begin
                    if ((nib == 4'h4 && carry) || (nib == 4'h5 && !carry)) model_jump(1, 0);
                    else begin
                        m_mode = M_SKIP; m_rem = 2;
                    end
`endif
                end else begin
                    e_other = 1;
                end
            end
            M_AFTER0: begin
                e_blk = 0; m_mode = M_IDLE;
            end
            M_AFTER8: begin
                if (nib >= 4'hC) model_jump((nib[0] ? 4 : 3), nib >= 4'hE);
                else begin
                    e_other = 1; m_mode = M_IDLE;
                end
            end
            M_OFFSET: begin
                m_rem--;
                if (m_rem == 0) begin
                    e_jump = 0; e_len = 0; e_push = 0; m_mode = M_IDLE;
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic drive(input bit rst, input bit en, input logic [3:0] ph, input bit bb,
                         input bit eb, input bit st, input logic [3:0] nib, input bit c);
        i_reset = rst; i_clk_en = en; i_phases = ph; i_bus_busy = bb;
        i_exec_unit_busy = eb; i_instr_start = st; i_nibble = nib; i_carry = c;
        @(posedge clk);
        #1;
        model_step(rst, en && ph[2] && !bb && !eb, st, nib, c);
        check_eq("jump", {7'd0, o_jump_instr}, {7'd0, e_jump});
        check_eq("len", {5'd0, o_jump_length}, 8'(e_len));
        check_eq("push", {7'd0, o_push_pc}, {7'd0, e_push});
        check_eq("blk0x", {7'd0, o_block_0x}, {7'd0, e_blk});
        check_eq("other", {7'd0, o_other_instr}, {7'd0, e_other});
        check_eq("busy", {7'd0, o_busy}, {7'd0, m_mode != M_IDLE});
    endtask

    task automatic slot_nib(input bit st, input logic [3:0] nib, input bit c);
        drive(0, 1, 4'b0100, 0, 0, st, nib, c);
    endtask

    task automatic do_reset();
        drive(1, 0, 4'b0000, 0, 0, 0, 4'h0, 0);
        drive(1, 1, 4'b0100, 0, 0, 1, 4'h6, 0);
    endtask

    logic [3:0] nib;
    bit         st;
    int         sel;

    initial begin
        do_reset();
        check_eq("rst_busy", {7'd0, o_busy}, 8'd0);

        // GOTO 6 4 3 2 with a 3-cycle stall after the second offset nibble.
        slot_nib(1, 4'h6, 0);
        check_eq("goto_len", {5'd0, o_jump_length}, 8'd2);
        slot_nib(0, 4'h4, 0);
        slot_nib(0, 4'h3, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 4'b0100, 1, 0, 0, 4'h2, 0);
        check_eq("stall_hold", {7'd0, o_jump_instr}, 8'd1);
        slot_nib(0, 4'h2, 0);
        check_eq("goto_done", {7'd0, o_jump_instr}, 8'd0);

        // GOSUB then a normal GOTO start; GOVLNG; GOSUBL.
        slot_nib(1, 4'h7, 0);
        check_eq("gosub_push", {7'd0, o_push_pc}, 8'd1);
        slot_nib(1, 4'h0, 0);
        slot_nib(0, 4'h1, 0);
        slot_nib(0, 4'h0, 0);
        slot_nib(1, 4'h6, 0);
        for (int i = 0; i < 3; i++) slot_nib(0, 4'h5, 0);
        slot_nib(1, 4'h8, 0);
        slot_nib(0, 4'hD, 0);
        check_eq("govlng_len", {5'd0, o_jump_length}, 8'd4);
        for (int i = 0; i < 5; i++) slot_nib(0, 4'h0, 0);
        check_eq("govlng_done", {7'd0, o_busy}, 8'd0);
        slot_nib(1, 4'h8, 0);
        slot_nib(0, 4'hE, 0);
        check_eq("gosubl_len", {5'd0, o_jump_length}, 8'd3);
        for (int i = 0; i < 4; i++) slot_nib(0, 4'h9, 0);

        // RTN and an unhandled start nibble.
        slot_nib(1, 4'h0, 0);
        check_eq("rtn_blk", {7'd0, o_block_0x}, 8'd1);
        slot_nib(0, 4'h1, 0);
        check_eq("rtn_blk_off", {7'd0, o_block_0x}, 8'd0);
        slot_nib(1, 4'hA, 0);
        check_eq("other_pulse", {7'd0, o_other_instr}, 8'd1);
        slot_nib(0, 4'h3, 0);

        // Reset in the middle of a GOSUB offset.
        slot_nib(1, 4'h7, 0);
        slot_nib(0, 4'h1, 0);
        drive(1, 1, 4'b0100, 0, 0, 0, 4'h2, 0);
        check_eq("rst_mid", {4'd0, o_jump_instr, o_push_pc, o_busy, |o_jump_length}, 8'd0);

`ifdef SATURN_COND_JUMP_EN
        slot_nib(1, 4'h4, 0);
        slot_nib(0, 4'h1, 0);
        slot_nib(0, 4'h2, 0);
        check_eq("goc_skip", {7'd0, o_busy}, 8'd0);
        slot_nib(1, 4'h5, 0);
        check_eq("gonc_len", {5'd0, o_jump_length}, 8'd1);
        slot_nib(0, 4'h1, 0);
        slot_nib(0, 4'h2, 0);
`endif

        // Random stream biased toward jump opcodes.
        for (int i = 0; i < 4000; i++) begin
            if (m_mode == M_IDLE) st = ($urandom_range(0, 7) != 0);
            else st = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 7);
            if (m_mode == M_AFTER8) begin
                nib = (sel < 6) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            end else begin
                case (sel)
                    0: nib = 4'h0;
                    1: nib = 4'h6;
                    2: nib = 4'h7;
                    3: nib = 4'h8;
                    4: nib = 4'h4;
                    5: nib = 4'h5;
                    default: nib = 4'($urandom_range(0, 15));
                endcase
            end
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) != 0,
                  ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0100,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  st, nib, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/saturn_jump_decoder.md
# saturn_jump_decoder

Nibble-serial pre-decoder for the Saturn control-transfer instructions (RTN family, GOTO/GOSUB, GOLONG/GOVLNG/GOSUBL/GOSBVL). It sits directly upstream of the PC/return-stack block. It watches the fetched nibble stream and produces the jump strobe, offset length, push request and `0x`-block flag that the PC/RSTK block consumes. It also counts offset nibbles so its strobes frame each jump exactly.

## Interface
Parameters: none.

- `i_clk` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_clk_en` in 1: global clock enable.
- `i_phases` in 4: one-hot phase strobes; decoding happens only on `i_phases[2]`.
- `i_bus_busy` in 1: stall.
- `i_exec_unit_busy` in 1: stall.
- `i_nibble` in 4: current fetched nibble, valid in phase 2.
- `i_instr_start` in 1: the current nibble is the first nibble of an instruction.
- `i_carry` in 1: carry flag; used only with `SATURN_COND_JUMP_EN`.
- `o_jump_instr` out 1: a jump is in progress; covers the last opcode nibble and all offset nibbles.
- `o_jump_length` out 3: 1 = rel2, 2 = rel3, 3 = rel4, 4 = abs5; 0 when idle.
- `o_push_pc` out 1: the jump is a GOSUB variant.
- `o_block_0x` out 1: the previous nibble was an instruction-start `0`.
- `o_other_instr` out 1: one-slot pulse; the first nibble is not handled here.
- `o_busy` out 1: state is not IDLE.

## Operation
A slot is any edge where `i_clk_en && i_phases[2] && !i_bus_busy && !i_exec_unit_busy`. State and outputs change only on slots or on reset.

States:
- **IDLE**: acts on a slot with `i_instr_start`.
  - `0` → BLK0.
  - `8` → BLK8.
  - `6` → OFFSET with length 2, push 0.
  - `7` → OFFSET with length 2, push 1.
  - Any other nibble → pulse `o_other_instr` and stay in IDLE.
  - With `i_instr_start` low, stay in IDLE.
- **BLK0**: `o_block_0x` = 1. The next slot returns to IDLE and clears the flag, whatever the nibble.
- **BLK8**:
  - `C` → OFFSET, length 3, push 0.
  - `D` → OFFSET, length 4, push 0.
  - `E` → OFFSET, length 3, push 1.
  - `F` → OFFSET, length 4, push 1.
  - Any other nibble → pulse `o_other_instr`, then IDLE.
- **OFFSET**:
  - `o_jump_instr` = 1. `o_jump_length` and `o_push_pc` are held.
  - A 3-bit counter starts at 0 and increments on each slot.
  - On the slot where counter == length, clear all jump outputs and go to IDLE. This covers length+1 offset nibbles: 2, 3, 4 or 5.
- **SKIP** (macro only): consumes 2 nibbles with all jump outputs at 0, then goes to IDLE.

Boundary rules:
- `i_instr_start` asserted in BLK0, BLK8, OFFSET or SKIP is ignored; the in-flight instruction has priority.
- A stall freezes the state, counter and all outputs.
- Reset wins over any slot in the same cycle.
- Reset mid-operation aborts to IDLE with no residual strobes.

## Timing
- Every output is registered. Reset value of every output is 0, and the state is IDLE.
- Outputs update on the slot edge, so they are valid from the following `i_phases[3]` onward. The PC/RSTK block starts its jump decode in that phase 3.
- `o_jump_instr` is still high at the slot edge of the last offset nibble. It is low after that edge.
- `o_block_0x` is high during exactly the slot after the `0` nibble, so the RTN check sees it.
- `o_other_instr` is high from one slot edge until the next slot edge.
- Latency from opcode nibble to strobe is 1 slot edge. Throughput is 1 nibble per slot.

## Configuration
- `SATURN_COND_JUMP_EN` defined:
  - IDLE also decodes `4` (GOC) and `5` (GONC).
  - If the condition holds (GOC with `i_carry` = 1, or GONC with `i_carry` = 0) → OFFSET, length 1, push 0.
  - Otherwise → SKIP.
  - `i_carry` is sampled on the opcode slot.
- Not defined: `4` and `5` pulse `o_other_instr`, and `i_carry` is unused.

## Structure
- Shared package `saturn_jump_pkg` holds:
  - the state enum (IDLE, BLK0, BLK8, OFFSET, SKIP);
  - the length constants JL_NONE = 0, JL_REL2 = 1, JL_REL3 = 2, JL_REL4 = 3, JL_ABS5 = 4, which the PC/RSTK block also uses.
- One sub-module, `saturn_jump_opcode_lut`: combinational map from (state, nibble, carry) to (next state, length, push, other).

## Test plan
1. GOTO: start `6`, then offsets `4`,`3`,`2` → `o_jump_instr` = 1, length 2, push 0 after the `6` slot; low after the `2` slot; `o_busy` for 4 slots.
2. GOSUB: `7` `0` `1` `0` → same framing with `o_push_pc` = 1; return to IDLE; a following `i_instr_start` `6` is decoded normally.
3. GOVLNG: `8` `D` `0` `0` `0` `0` `1` → length 4 after `D`; strobe spans 5 offset nibbles; GOSUBL `8` `E` gives length 3, push 1.
4. RTN: `0` `1` → `o_block_0x` high for one slot only, no jump strobe. Start nibble `A` → `o_other_instr` one-slot pulse.
5. Stall: assert `i_bus_busy` for 3 cycles after the 2nd offset nibble of a GOTO → counter and outputs frozen; completion after 1 more slot once released. Reset asserted mid-OFFSET → all outputs 0 on the next edge.
6. With macro: `4` with `i_carry` = 0 → SKIP, no strobe, IDLE after 2 nibbles. `5` with `i_carry` = 0 → length 1 strobe over 2 nibbles.
